// File: rtl/proc_io_host_pkg.sv
// proc_io_pkg: default widths, sample types and index helper shared by proc_io_host
package proc_io_pkg;
   localparam int NBIN_DEF = 19;
   localparam int NBOUT_DEF = 28;
   localparam int NUIOIN_DEF = 4;
   localparam int NUIOOU_DEF = 4;
   localparam int FDEPTH_DEF = 8;
   typedef logic signed [NBIN_DEF-1:0] in_smp_t;
   typedef logic signed [NBOUT_DEF-1:0] out_smp_t;
   // Index of the lowest set bit; 0 when no bit is set.
   function automatic int onehot_to_idx(input logic [31:0] v);
      int r;
      r = 0;
      for (int i = 31; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction
endpackage

// File: rtl/proc_io_host_if.sv
// proc_io_host_if: host write/read handshakes, processor strobes and error flags
//  master: host/processor side (drives wr_*, req_in, out_en, io_out, rd_ready, clr_err)
//  slave:  proc_io_host side (drives wr_ready, io_in, rd_*, underflow, overflow)
interface proc_io_host_if #(
   parameter int NBIN = proc_io_pkg::NBIN_DEF,
   parameter int NBOUT = proc_io_pkg::NBOUT_DEF,
   parameter int NUIOIN = proc_io_pkg::NUIOIN_DEF,
   parameter int NUIOOU = proc_io_pkg::NUIOOU_DEF
);
   logic wr_valid;
   logic [$clog2(NUIOIN)-1:0] wr_port;
   logic [NBIN-1:0] wr_data;
   logic wr_ready;
   logic [NUIOIN-1:0] req_in;
   logic [NBIN-1:0] io_in;
   logic [NUIOOU-1:0] out_en;
   logic [NBOUT-1:0] io_out;
   logic rd_valid;
   logic [$clog2(NUIOOU)-1:0] rd_port;
   logic [NBOUT-1:0] rd_data;
   logic rd_ready;
   logic [NUIOIN-1:0] underflow;
   logic [NUIOOU-1:0] overflow;
   logic clr_err;
   modport master(
      output wr_valid, wr_port, wr_data, req_in, out_en, io_out, rd_ready, clr_err,
      input wr_ready, io_in, rd_valid, rd_port, rd_data, underflow, overflow
   );
   modport slave(
      input wr_valid, wr_port, wr_data, req_in, out_en, io_out, rd_ready, clr_err,
      output wr_ready, io_in, rd_valid, rd_port, rd_data, underflow, overflow
   );
endinterface

// File: rtl/proc_io_host_fifo.sv
// io_fifo: synchronous show-ahead FIFO
//  push/din: write when not full; pop: read when not empty; head: oldest entry
//  full/empty: flags from the pre-cycle occupancy
module io_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 8
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic pop,
   input logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   // A push on a full FIFO is dropped even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign head = mem[rp];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) mem[wp] <= din;
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/proc_io_host.sv
// proc_io_host: buffers host samples for processor input ports, collects processor outputs for the host
//  clk/rst: clock, synchronous active-high reset
//  bus: host write channel, processor req_in/io_in and out_en/io_out, host read channel, sticky flags
module proc_io_host
   import proc_io_pkg::*;
#(
   parameter int NBIN = NBIN_DEF,
   parameter int NBOUT = NBOUT_DEF,
   parameter int NUIOIN = NUIOIN_DEF,
   parameter int NUIOOU = NUIOOU_DEF,
   parameter int FDEPTH = FDEPTH_DEF
) (
   input logic clk,
   input logic rst,
   proc_io_host_if.slave bus
);
   localparam int IPW = $clog2(NUIOIN);
   localparam int OPW = $clog2(NUIOOU);
   logic [NBIN-1:0] ihead [NUIOIN];
   logic [NBIN-1:0] hold [NUIOIN];
   logic [NUIOIN-1:0] iempty, ifull, uf_set;
   logic [NBOUT-1:0] ohead [NUIOOU];
   logic [NUIOOU-1:0] oempty, ofull;
   logic [IPW-1:0] rsel;
   logic [OPW-1:0] rr_ptr, rr_sel, lock_sel, sel, idx;
   logic req_any, lock, acc;
   assign req_any = |bus.req_in;
   assign rsel = IPW'(onehot_to_idx(32'(bus.req_in)));
   for (genvar k = 0; k < NUIOIN; k++) begin : g_in
      io_fifo #(.W(NBIN), .DEPTH(FDEPTH)) u_fifo (
         .clk(clk),
         .rst(rst),
         .push(bus.wr_valid && bus.wr_port == IPW'(k)),
         .pop(req_any && rsel == IPW'(k)),
         .din(bus.wr_data),
         .head(ihead[k]),
         .full(ifull[k]),
         .empty(iempty[k])
      );
   end
   for (genvar k = 0; k < NUIOOU; k++) begin : g_out
      io_fifo #(.W(NBOUT), .DEPTH(FDEPTH)) u_fifo (
         .clk(clk),
         .rst(rst),
         .push(bus.out_en[k]),
         .pop(acc && sel == OPW'(k)),
         .din(bus.io_out),
         .head(ohead[k]),
         .full(ofull[k]),
         .empty(oempty[k])
      );
   end
   assign bus.wr_ready = !ifull[bus.wr_port];
   // An empty port replays the last sample it delivered.
   assign bus.io_in = !req_any ? '0 : iempty[rsel] ? hold[rsel] : ihead[rsel];
   assign uf_set = {NUIOIN{req_any && iempty[rsel]}} & (NUIOIN'(1) << rsel);
   // First non-empty output FIFO at or after rr_ptr; descending scan lets the nearest win.
   always_comb begin
      rr_sel = rr_ptr;
      idx = rr_ptr;
      for (int i = NUIOOU - 1; i >= 0; i--) begin
         idx = OPW'((int'(rr_ptr) + i) % NUIOOU);
         if (!oempty[idx]) rr_sel = idx;
      end
   end
   // Once offered, the choice is frozen until the host accepts it.
   assign sel = lock ? lock_sel : rr_sel;
   assign bus.rd_valid = |(~oempty);
   assign acc = bus.rd_valid && bus.rd_ready;
   assign bus.rd_port = sel;
   assign bus.rd_data = bus.rd_valid ? ohead[sel] : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         lock <= 1'b0;
         lock_sel <= '0;
         bus.underflow <= '0;
         bus.overflow <= '0;
         for (int i = 0; i < NUIOIN; i++) hold[i] <= '0;
      end else begin
         if (req_any && !iempty[rsel]) hold[rsel] <= ihead[rsel];
         bus.underflow <= (bus.underflow & ~{NUIOIN{bus.clr_err}}) | uf_set;
         bus.overflow <= (bus.overflow & ~{NUIOOU{bus.clr_err}}) | (bus.out_en & ofull);
         if (acc) begin
            rr_ptr <= OPW'((int'(sel) + 1) % NUIOOU);
            lock <= 1'b0;
         end else if (bus.rd_valid) begin
            lock <= 1'b1;
            lock_sel <= sel;
         end
      end
   end
endmodule

// File: tb/tb_proc_io_host.sv
// tb_proc_io_host: scoreboard bench for proc_io_host input buffering, output draining and flags
module tb_proc_io_host;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   proc_io_host_if bus();
   proc_io_host dut(.clk(clk), .rst(rst), .bus(bus));
   int n_chk = 0;
   int n_err = 0;
   logic [18:0] iq[4][$];
   logic [18:0] hold_m[4];
   logic [27:0] oq[4][$];
   logic [3:0] uf_m, of_m;
   int rr_m, lport_m;
   bit lock_m;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic idle_inputs();
      bus.wr_valid = 1'b0;
      bus.wr_port = '0;
      bus.wr_data = '0;
      bus.req_in = '0;
      bus.out_en = '0;
      bus.io_out = '0;
      bus.rd_ready = 1'b0;
      bus.clr_err = 1'b0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iq[i].delete();
         oq[i].delete();
         hold_m[i] = '0;
      end
      uf_m = '0;
      of_m = '0;
      rr_m = 0;
      lock_m = 1'b0;
      lport_m = 0;
   endtask
   // One cycle: drive at negedge, compare against the model just after, then advance the model.
   task automatic tick(input bit wv, input int wp, input int wd, input logic [3:0] rq,
                       input logic [3:0] oe, input int od, input bit rr, input bit clr);
      int k, p;
      bit wacc;
      logic [3:0] ofl;
      @(negedge clk);
      bus.wr_valid = wv;
      bus.wr_port = 2'(wp);
      bus.wr_data = 19'(wd);
      bus.req_in = rq;
      bus.out_en = oe;
      bus.io_out = 28'(od);
      bus.rd_ready = rr;
      bus.clr_err = clr;
      #1;
      wacc = wv && iq[wp].size() < 8;
      check("wr_ready", bus.wr_ready, iq[wp].size() < 8);
      k = -1;
      for (int i = 3; i >= 0; i--) if (rq[i]) k = i;
      if (k < 0) check("io_in_idle", bus.io_in, 0);
      else check("io_in", bus.io_in, iq[k].size() > 0 ? iq[k][0] : hold_m[k]);
      check("underflow", bus.underflow, uf_m);
      check("overflow", bus.overflow, of_m);
      p = lock_m ? lport_m : -1;
      if (!lock_m) for (int i = 3; i >= 0; i--) if (oq[(rr_m + i) % 4].size() > 0) p = (rr_m + i) % 4;
      check("rd_valid", bus.rd_valid, p >= 0);
      if (p >= 0) begin
         check("rd_port", bus.rd_port, p);
         check("rd_data", bus.rd_data, oq[p][0]);
      end
      for (int i = 0; i < 4; i++) ofl[i] = oq[i].size() >= 8;
      if (clr) begin
         uf_m = '0;
         of_m = '0;
      end
      if (k >= 0) begin
         if (iq[k].size() > 0) hold_m[k] = iq[k].pop_front();
         else uf_m[k] = 1'b1;
      end
      if (wacc) iq[wp].push_back(19'(wd));
      if (p >= 0 && rr) begin
         void'(oq[p].pop_front());
         rr_m = (p + 1) % 4;
         lock_m = 1'b0;
      end else if (p >= 0) begin
         lock_m = 1'b1;
         lport_m = p;
      end
      for (int i = 0; i < 4; i++) if (oe[i]) begin
         if (ofl[i]) of_m[i] = 1'b1;
         else oq[i].push_back(28'(od));
      end
   endtask
   initial begin
      idle_inputs();
      do_reset();
      tick(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tick(1, 2, 5, 4'b0000, 4'b0000, 0, 0, 0);
      tick(1, 2, -3, 4'b0000, 4'b0000, 0, 0, 0);
      tick(0, 2, 0, 4'b0100, 4'b0000, 0, 0, 0);
      tick(0, 2, 0, 4'b0100, 4'b0000, 0, 0, 0);
      tick(0, 2, 0, 4'b0100, 4'b0000, 0, 0, 0);
      tick(0, 2, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tick(0, 2, 0, 4'b0100, 4'b0000, 0, 0, 1);
      tick(0, 2, 0, 4'b0000, 4'b0000, 0, 0, 1);
      tick(0, 2, 0, 4'b0000, 4'b0000, 0, 0, 0);
      for (int i = 0; i < 8; i++) tick(1, 0, 1000 + i * 17, 4'b0000, 4'b0000, 0, 0, 0);
      tick(1, 0, 99, 4'b0000, 4'b0000, 0, 0, 0);
      tick(0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tick(1, 0, 50, 4'b0001, 4'b0000, 0, 0, 0);
      tick(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tick(1, 0, 60, 4'b0001, 4'b0000, 0, 0, 0);
      for (int i = 0; i < 9; i++) tick(0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
      do_reset();
      tick(0, 0, 0, 4'b0000, 4'b0001, 100, 1, 0);
      tick(0, 0, 0, 4'b0000, 4'b0100, -7, 1, 0);
      tick(0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
      tick(0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
      for (int i = 0; i < 9; i++) tick(0, 0, 0, 4'b0000, 4'b0010, 200 + i, 0, 0);
      tick(0, 0, 0, 4'b0000, 4'b0001, 77, 0, 0);
      tick(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      tick(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1);
      tick(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      for (int i = 0; i < 10; i++) tick(0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
      for (int i = 0; i < 4; i++) tick(1, i, -100 - i, 4'b0000, 4'b1111, 300 + i, 0, 0);
      tick(0, 0, 0, 4'b1000, 4'b0000, 0, 0, 0);
      tick(0, 0, 0, 4'b0010, 4'b0000, 0, 0, 0);
      do_reset();
      tick(0, 0, 0, 4'b0010, 4'b0000, 0, 0, 0);
      tick(0, 3, 0, 4'b0000, 4'b0000, 0, 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
